// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode stage, the alu_issue stage and the ALU inputs.
// The slave modport is the issue stage's view; master is the surrounding pipeline's view.
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_in1;
    logic [31:0] out_in2;
    logic [3:0]  out_alu_op;
    logic        out_branch;
    logic        out_illegal;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
        output in_ready, out_valid, out_in1, out_in2, out_alu_op, out_branch, out_illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
        input  in_ready, out_valid, out_in1, out_in2, out_alu_op, out_branch, out_illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode-to-execute issue stage: builds ALU operands/op from a decoded instruction.
// Define ALU_ISSUE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module alu_issue (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_XOR = 4'h2, ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4, ALU_SLL = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_EQ  = 4'h8, ALU_NE  = 4'h9, ALU_LT  = 4'hA, ALU_LTU = 4'hB;
    localparam logic [3:0] ALU_GE  = 4'hC, ALU_GEU = 4'hD;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic        branch;
        logic        illegal;
    } entry_t;

    function automatic logic [3:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_op = ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_LT;
            3'b011:  arith_op = ALU_LTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
        entry_t      e;
        logic        ok;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_u, shamt;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = {{20{inst[31]}}, inst[31:20]};
        imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_u = {inst[31:12], 12'b0};
        shamt = {27'b0, inst[24:20]};
        ok    = 1'b1;
        e     = '{in1: rs1, in2: rs2, op: ALU_ADD, branch: 1'b0, illegal: 1'b0};
        case (inst[6:0])
            7'b0110011: begin
                e.op = arith_op(f3);
                case (f3)
                    3'b000:  if (f7 == 7'b0100000) e.op = ALU_SUB; else ok = (f7 == 7'b0);
                    3'b101:  if (f7 == 7'b0100000) e.op = ALU_SRA; else ok = (f7 == 7'b0);
                    default: ok = (f7 == 7'b0);
                endcase
            end
            7'b0010011: begin
                e.in2 = imm_i;
                e.op  = arith_op(f3);
                // Only the shift forms constrain funct7; shamt replaces the immediate
                if (f3 == 3'b001) begin
                    e.in2 = shamt;
                    ok    = (f7 == 7'b0);
                end else if (f3 == 3'b101) begin
                    e.in2 = shamt;
                    if (f7 == 7'b0100000) e.op = ALU_SRA; else ok = (f7 == 7'b0);
                end
            end
            7'b0000011: e.in2 = imm_i;
            7'b0100011: e.in2 = imm_s;
            7'b0110111: begin e.in1 = 32'b0; e.in2 = imm_u; end
            7'b0010111: begin e.in1 = pc;    e.in2 = imm_u; end
            7'b1101111,
            7'b1100111: begin e.in1 = pc;    e.in2 = 32'd4; end
            7'b1100011: begin
                e.branch = 1'b1;
                case (f3)
                    3'b000:  e.op = ALU_EQ;
                    3'b001:  e.op = ALU_NE;
                    3'b100:  e.op = ALU_LT;
                    3'b101:  e.op = ALU_GE;
                    3'b110:  e.op = ALU_LTU;
                    3'b111:  e.op = ALU_GEU;
                    default: ok = 1'b0;
                endcase
            end
            default: ok = 1'b0;
        endcase
        if (!ok) e = '{in1: 32'b0, in2: 32'b0, op: ALU_ADD, branch: 1'b0, illegal: 1'b1};
        return e;
    endfunction

    entry_t main_q, main_d;
    logic   main_vld_q, main_vld_d;
    entry_t dec;
    logic   accept, pop;

    assign dec    = decode(bus.in_inst, bus.in_pc, bus.in_rs1, bus.in_rs2);
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = main_vld_q && bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_vld_q, skid_vld_d;

    // Upstream only sees the skid occupancy flop, never out_ready
    assign bus.in_ready = !skid_vld_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (!main_vld_q || pop) begin
            main_vld_d = accept;
            if (accept) main_d = dec;
        end else if (accept) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`else
    assign bus.in_ready = !main_vld_q || bus.out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = dec;
            main_vld_d = 1'b1;
        end else if (pop) begin
            main_vld_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end

    assign bus.out_valid   = main_vld_q;
    assign bus.out_in1     = main_q.in1;
    assign bus.out_in2     = main_q.in2;
    assign bus.out_alu_op  = main_q.op;
    assign bus.out_branch  = main_q.branch;
    assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: random and directed instructions against a table-driven model.
// Expectations for buffering depth follow ALU_ISSUE_SKID_EN.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef ALU_ISSUE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic        br;
        logic        ill;
    } exp_t;

    // funct3 -> op for OP/OP-IMM; branch table bit 4 marks an illegal funct3
    localparam logic [3:0] OP_TBL [8] = '{4'h0, 4'h5, 4'hA, 4'hB, 4'h2, 4'h6, 4'h3, 4'h4};
    localparam logic [4:0] BR_TBL [8] = '{5'h08, 5'h09, 5'h10, 5'h10, 5'h0A, 5'h0C, 5'h0B, 5'h0D};
    localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63};

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        bit          legal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_u;
        logic [4:0]  br;
        f3    = inst[14:12];
        f7    = inst[31:25];
        imm_i = $signed(inst) >>> 20;
        imm_s = (imm_i & ~32'h1F) | ((inst >> 7) & 32'h1F);
        imm_u = inst & 32'hFFFF_F000;
        legal = 1'b1;
        e     = '{in1: r1, in2: r2, op: 4'h0, br: 1'b0, ill: 1'b0};
        if (inst[6:0] == 7'h33) begin
            e.op = OP_TBL[f3];
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.op = (f3 == 3'd0) ? 4'h1 : 4'h7;
            else if (f7 != 7'h00) legal = 1'b0;
        end else if (inst[6:0] == 7'h13) begin
            e.in2 = imm_i;
            e.op  = OP_TBL[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.in2 = (inst >> 20) & 32'd31;
                if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'h7;
                else if (f7 != 7'h00) legal = 1'b0;
            end
        end else if (inst[6:0] == 7'h03) e.in2 = imm_i;
        else if (inst[6:0] == 7'h23) e.in2 = imm_s;
        else if (inst[6:0] == 7'h37) begin e.in1 = 0;  e.in2 = imm_u; end
        else if (inst[6:0] == 7'h17) begin e.in1 = pc; e.in2 = imm_u; end
        else if (inst[6:0] == 7'h6F || inst[6:0] == 7'h67) begin e.in1 = pc; e.in2 = 4; end
        else if (inst[6:0] == 7'h63) begin
            br    = BR_TBL[f3];
            e.br  = 1'b1;
            e.op  = br[3:0];
            legal = !br[4];
        end else legal = 1'b0;
        if (!legal) e = '{in1: 0, in2: 0, op: 4'h0, br: 1'b0, ill: 1'b1};
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] inst;
        int          k;
        inst = $urandom;
        k    = $urandom_range(0, 9);
        if (k < 9) inst[6:0] = OPCS[k];
        case ($urandom_range(0, 3))
            0, 2:    inst[31:25] = 7'h00;
            1:       inst[31:25] = 7'h20;
            default: ;
        endcase
        return inst;
    endfunction

    // Monitor: compare presented output to scoreboard head every cycle, pop on transfer
    always @(negedge clk) begin
        if (!rst) begin
            exp_t got;
            logic exp_vld, exp_rdy;
            exp_vld = (q.size() > 0);
`ifdef ALU_ISSUE_SKID_EN
            exp_rdy = (q.size() < 2);
`else
            exp_rdy = (q.size() == 0) || bus.out_ready;
`endif
            n_tests++;
            if (bus.out_valid !== exp_vld || bus.in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL handshake t=%0t out_valid=%b in_ready=%b required out_valid=%b in_ready=%b",
                         $time, bus.out_valid, bus.in_ready, exp_vld, exp_rdy);
            end
            if (exp_vld && bus.out_valid === 1'b1) begin
                got = '{in1: bus.out_in1, in2: bus.out_in2, op: bus.out_alu_op,
                        br: bus.out_branch, ill: bus.out_illegal};
                n_tests++;
                if (got !== q[0]) begin
                    n_fail++;
                    $display("FAIL out_data t=%0t got in1=%h in2=%h op=%h br=%b ill=%b required in1=%h in2=%h op=%h br=%b ill=%b",
                             $time, got.in1, got.in2, got.op, got.br, got.ill,
                             q[0].in1, q[0].in2, q[0].op, q[0].br, q[0].ill);
                end
                if (bus.out_ready && !bus.flush) void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic cycle(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2, input bit fl, output bit acc);
        bus.in_valid = v;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        bus.in_rs1   = r1;
        bus.in_rs2   = r2;
        bus.flush    = fl;
        @(negedge clk);
        #1;
        acc = v && bus.in_ready && !fl;
        if (fl) q.delete();
        else if (acc) q.push_back(model(inst, pc, r1, r2));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) cycle(1'b1, inst, pc, r1, r2, 1'b0, acc);
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout inst=%h accepted=0 required=1", inst);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'b0, 32'b0, 32'b0, 32'b0, 1'b0, acc);
    endtask

    task automatic check_out(input string name, input logic vld, input logic [31:0] in1,
                             input logic [31:0] in2, input logic [3:0] op, input logic br,
                             input logic ill);
        n_tests++;
        if (bus.out_valid !== vld || bus.out_in1 !== in1 || bus.out_in2 !== in2 ||
            bus.out_alu_op !== op || bus.out_branch !== br || bus.out_illegal !== ill) begin
            n_fail++;
            $display("FAIL %s got v=%b in1=%h in2=%h op=%h br=%b ill=%b required v=%b in1=%h in2=%h op=%h br=%b ill=%b",
                     name, bus.out_valid, bus.out_in1, bus.out_in2, bus.out_alu_op,
                     bus.out_branch, bus.out_illegal, vld, in1, in2, op, br, ill);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%b required=%b", name, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        bus.flush = 0; bus.in_valid = 0; bus.in_inst = 0; bus.in_pc = 0;
        bus.in_rs1 = 0; bus.in_rs2 = 0; bus.out_ready = 0;

        #1 rst = 1'b1;
        #2;
        check_out("reset_outputs", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        check_bit("reset_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed decode cases, each held with out_ready=0 then drained
        send(32'h002081B3, 32'h0, 32'd4, 32'd6);
        check_out("add", 1'b1, 32'd4, 32'd6, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1; idle(2); bus.out_ready = 0;
        send(32'h4040D293, 32'h0, 32'hF0000004, 32'h0);
        check_out("srai", 1'b1, 32'hF0000004, 32'd4, 4'h7, 1'b0, 1'b0);
        bus.out_ready = 1; idle(2); bus.out_ready = 0;
        send(32'h2040D293, 32'h0, 32'hF0000004, 32'h0);
        check_out("srai_bad_f7", 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        bus.out_ready = 1; idle(2); bus.out_ready = 0;
        send(32'h0020E063, 32'h0, 32'hF0000004, 32'd4);
        check_out("bltu", 1'b1, 32'hF0000004, 32'd4, 4'hB, 1'b1, 1'b0);
        bus.out_ready = 1; idle(2); bus.out_ready = 0;
        send(32'h12345097, 32'h100, 32'h0, 32'h0);
        check_out("auipc", 1'b1, 32'h100, 32'h12345000, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1; idle(2); bus.out_ready = 0;

        // Stall: stream three with out_ready low, count how many get in
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, rand_inst(), $urandom, $urandom, $urandom, 1'b0, acc);
            n_acc += int'(acc);
        end
        n_tests++;
        if (n_acc != DEPTH) begin
            n_fail++;
            $display("FAIL stall_accepts got=%0d required=%0d", n_acc, DEPTH);
        end
        idle(3);
        bus.out_ready = 1; idle(4); bus.out_ready = 0;

        // Flush with buffer full plus a same-cycle input
        for (int i = 0; i < DEPTH; i++) send(rand_inst(), $urandom, $urandom, $urandom);
        cycle(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b1, acc);
        check_bit("flush_out_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1; idle(4);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit fl;
            fl = ($urandom_range(0, 39) == 0);
            bus.out_ready = fl ? 1'b0 : ($urandom_range(0, 9) < 7);
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom, fl, acc);
        end
        bus.out_ready = 1; idle(4);

        // Asynchronous reset in the middle of a stalled stream
        bus.out_ready = 0;
        send(rand_inst(), $urandom, $urandom, $urandom);
        bus.in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_out("midreset_outputs", 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        check_bit("midreset_in_ready", bus.in_ready, 1'b1);
        q.delete();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        send(32'h002081B3, 32'h0, 32'd4, 32'd6);
        check_out("post_reset_add", 1'b1, 32'd4, 32'd6, 4'h0, 1'b0, 1'b0);
        bus.out_ready = 1; idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
